shift_add_multiplier: RTL and testbench

- Sequential 32x32 shift-add multiplier for the MIPS ALU; the multiply counterpart of the divider.
- Produces the 64-bit product as Out[63:32] = HI and Out[31:0] = LO, in the same layout as the divider's 64-bit Out.
- Serves both mult (signed) and multu (unsigned).
- Uses a start/busy/done handshake so the control unit can stall while it runs.

---
 rtl/shift_add_multiplier_pkg.sv | 18 +
 rtl/shift_add_multiplier_adder.sv | 16 +
 rtl/shift_add_multiplier.sv | 106 ++++++++++
 tb/tb_shift_add_multiplier.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared ALU definitions for the sequential multiplier (and the divider's HI/LO layout).
package shift_add_multiplier_pkg;

    localparam int unsigned Width = 32;

    // HI/LO field positions inside the 64-bit Out bus.
    localparam int unsigned HiMsb = 2 * Width - 1;
    localparam int unsigned HiLsb = Width;
    localparam int unsigned LoMsb = Width - 1;
    localparam int unsigned LoLsb = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Per-iteration adder: adds the multiplicand into the accumulator's upper half.
module shift_add_multiplier_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    always_comb begin
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential signed/unsigned shift-add multiplier with start/busy/done handshake.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = Width
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Out
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    mul_state_e           state_q;
    logic [WIDTH-1:0]     mag_a_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 neg_q;
    logic [CntW-1:0]      cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   out_q;

    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH-1:0]     mag_b_d;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic [2*WIDTH-1:0]   acc_d;

    // Negating -2^(W-1) wraps back to 2^(W-1), which is exactly its unsigned magnitude.
    always_comb begin
        mag_a_d = (Signed && A[WIDTH-1]) ? -A : A;
        mag_b_d = (Signed && B[WIDTH-1]) ? -B : B;
        addend  = acc_q[0] ? mag_a_q : '0;
    end

    shift_add_multiplier_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (acc_q[2*WIDTH-1:WIDTH]),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Carry becomes bit 2W of the sum, then the whole (2W+1)-bit value shifts right by one.
    always_comb begin
        acc_d = {cout, sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            mag_a_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        mag_a_q <= mag_a_d;
                        acc_q   <= {{WIDTH{1'b0}}, mag_b_d};
                        neg_q   <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        out_q   <= neg_q ? -acc_d : acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Out  = out_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table, scoreboard, handshake corners.
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] out;

    int checks = 0;
    int passed = 0;

    logic [63:0] sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    shift_add_multiplier u_dut (
        .Clk    (clk),
        .Reset  (rst),
        .Start  (start),
        .Signed (sgn),
        .A      (a),
        .B      (b),
        .Busy   (busy),
        .Done   (done),
        .Out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        if (s) begin
            xe = {{32{x[31]}}, x};
            ye = {{32{y[31]}}, y};
        end else begin
            xe = {32'b0, x};
            ye = {32'b0, y};
        end
        return xe * ye;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drives Start for exactly one edge; returns at the negedge following the Start edge.
    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [63:0] exp);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        sgn   = s;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int busy_n, output bit seen);
        n = 0;
        busy_n = 0;
        seen = 1'b0;
        while (n <= 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_n++;
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic retire(input string name);
        logic [63:0] exp;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check(name, out, exp);
        end
    endtask

    task automatic run_vec(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic [63:0] exp);
        int  n;
        int  bn;
        bit  seen;
        launch(x, y, s, exp);
        wait_done(n, bn, seen);
        if (!seen) begin
            check({name, "_done_timeout"}, 64'd0, 64'd1);
            sb.delete();
        end else begin
            check({name, "_latency"}, 64'(n), 64'd32);
            check({name, "_busy_cycles"}, 64'(bn), 64'd32);
            check({name, "_busy_at_done"}, 64'(busy), 64'd0);
            retire(name);
            @(negedge clk);
            check({name, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        int  n;
        int  bn;
        int  dcount;
        bit  seen;
        bit  held;
        logic [63:0] first;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rs;

        vecs[0] = '{32'h0000FFFF, 32'h00010001, 1'b0, 64'h00000000FFFFFFFF};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vecs[4] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        vecs[6] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
        vecs[7] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};

        rst = 1'b1;
        start = 1'b0;
        sgn = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_out", out, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
        end

        for (int i = 0; i < 4; i++) begin
            rx = $urandom;
            ry = $urandom;
            rs = 1'($urandom_range(0, 1));
            run_vec($sformatf("rand%0d", i), rx, ry, rs, model(rx, ry, rs));
        end

        // Reset mid-run: Out currently holds a nonzero result from the last operation.
        launch(32'd7, 32'd9, 1'b0, model(32'd7, 32'd9, 1'b0));
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_out", out, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midreset_no_done", 64'(dcount), 64'd0);

        // Start held through RUN while operands churn; result must use the t0 operands.
        @(negedge clk);
        start = 1'b1;
        a = 32'd1234;
        b = 32'd5678;
        sgn = 1'b0;
        sb.push_back(model(32'd1234, 32'd5678, 1'b0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            sgn = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        wait_done(n, bn, seen);
        if (!seen) check("hold_done_timeout", 64'd0, 64'd1);
        else retire("hold_start");

        // Back-to-back: Start in the DONE cycle, first result stays on Out until the next Done.
        launch(32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1);
        wait_done(n, bn, seen);
        if (!seen) begin
            check("b2b_first_timeout", 64'd0, 64'd1);
        end else begin
            retire("b2b_first");
            first = out;
            start = 1'b1;
            a = 32'd2;
            b = 32'd3;
            sgn = 1'b0;
            sb.push_back(64'd6);
            @(negedge clk);
            start = 1'b0;
            check("b2b_restart_busy", 64'(busy), 64'd1);
            held = 1'b1;
            n = 0;
            while (n <= 40 && !done) begin
                if (out !== first) held = 1'b0;
                @(negedge clk);
                n++;
            end
            if (!done) begin
                check("b2b_second_timeout", 64'd0, 64'd1);
            end else begin
                check("b2b_first_held", 64'(held), 64'd1);
                check("b2b_latency", 64'(n + 1), 64'd33);
                retire("b2b_second");
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
